// File: rtl/inst_axi_bridge.sv
// Read-only bridge from the IF stage's sram-like instruction port to a single-beat AXI3 read channel.
// Latency: addrok is same-cycle combinational, AR issues the next cycle; R->IF is 0 cycles (1 cycle with INST_BRIDGE_RDATA_REG_EN).
// Backpressure: addrok is withheld while an AR is pending or MAX_OUTSTANDING reads are in flight; rready is always 1 out of reset.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   inst_sram_*              IF request port (wr/wstrb/wdata are ignored; every access is a read)
//   ar*                      AXI3 read-address channel (single beat, INCR, constant id AXI_ID)
//   r*                       AXI3 read-data channel (rid/rresp/rlast are ignored)
//
// Optional feature: define INST_BRIDGE_RDATA_REG_EN to register dataok/rdata by one cycle.
module inst_axi_bridge #(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [3:0] AXI_ID          = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  // IF-side sram-like port
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addrok,
  output logic        inst_sram_dataok,
  output logic [31:0] inst_sram_rdata,
  // AXI3 AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI3 R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic {AR_IDLE, AR_WAIT} ar_state_e;

  localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

  ar_state_e   ar_state_q;
  logic        arvalid_q;
  logic [31:0] araddr_q;
  logic [2:0]  arsize_q;
  logic [1:0]  cnt_q, cnt_d;
  logic        addrok;
  logic        dataok;

  // Write-side and response-metadata inputs have no function on a read-only, single-ID, single-beat path.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid, rresp, rlast};

  // A request still waiting on AR already counts in cnt_q, so the limit covers it too.
  assign addrok = !reset && (ar_state_q == AR_IDLE) && inst_sram_req && (cnt_q < MAX_CNT);
  assign inst_sram_addrok = addrok;

  // AR channel FSM; arvalid is a registered output of the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ar_state_q <= AR_IDLE;
      arvalid_q  <= 1'b0;
      araddr_q   <= 32'd0;
      arsize_q   <= 3'd0;
    end else begin
      case (ar_state_q)
        AR_IDLE: begin
          if (addrok) begin
            araddr_q   <= inst_sram_addr;
            arsize_q   <= {1'b0, inst_sram_size};
            arvalid_q  <= 1'b1;
            ar_state_q <= AR_WAIT;
          end
        end
        AR_WAIT: begin
          if (arready) begin
            arvalid_q  <= 1'b0;
            ar_state_q <= AR_IDLE;
          end
        end
        default: begin
          arvalid_q  <= 1'b0;
          ar_state_q <= AR_IDLE;
        end
      endcase
    end
  end

  assign arid    = AXI_ID;
  assign araddr  = araddr_q;
  assign arlen   = 4'd0;
  assign arsize  = arsize_q;
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = arvalid_q;

  // Bridge can always sink a beat: IF consumes dataok unconditionally.
  assign rready = ~reset;

`ifdef INST_BRIDGE_RDATA_REG_EN
  logic        dataok_q;
  logic [31:0] rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataok_q <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      dataok_q <= rvalid && rready;
      if (rvalid && rready) begin
        rdata_q <= rdata;
      end
    end
  end

  assign dataok          = dataok_q;
  assign inst_sram_rdata = rdata_q;
`else
  assign dataok          = rvalid && rready;
  assign inst_sram_rdata = rdata;
`endif

  assign inst_sram_dataok = dataok;

  // Outstanding counter; a beat with nothing outstanding (left over from a reset) must not wrap it.
  always_comb begin
    cnt_d = cnt_q;
    case ({addrok, dataok})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = (cnt_q != 2'd0) ? cnt_q - 2'd1 : 2'd0;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
